// File: rtl/control_sequencer_if.sv
//------------------------------------------------------------------------------
// control_sequencer_if
//   Bundle between the hardwired control sequencer and the Datapath.
//   slave  : sequencer side (receives ir / mem_ready, drives strobes).
//   master : Datapath / environment side.
//   Signals: ir[31:0], mem_ready, 14 Datapath strobes, reg_in[15:0],
//            reg_out[15:0], opcode[4:0], run, illegal, instr_count[CNT_W-1:0].
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface control_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      ir;
    logic             mem_ready;
    logic             PCout, PCin, IncPC, MARin, MDRin, MDRout, Read;
    logic             IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [15:0]      reg_in;
    logic [15:0]      reg_out;
    logic [4:0]       opcode;
    logic             run;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport slave (
        input  ir, mem_ready,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read,
        output IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin,
        output reg_in, reg_out, opcode, run, illegal, instr_count
    );

    modport master (
        output ir, mem_ready,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read,
        input  IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin,
        input  reg_in, reg_out, opcode, run, illegal, instr_count
    );
endinterface

`default_nettype wire

// File: rtl/control_sequencer.sv
//------------------------------------------------------------------------------
// control_sequencer
//   Hardwired control unit for the Datapath. Sequences instruction fetch
//   (T0-T2, with a memory-ready wait in T1), 3-register ALU execute (T3-T5),
//   mul/div execute writing LO then HI (T3-T6), nop and halt.
//   Ports:
//     clock - rising-edge system clock
//     clear - asynchronous active-high reset
//     bus   - control_sequencer_if.slave (ir/mem_ready in, strobes out)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_sequencer #(
    parameter int         CNT_W   = 16,
    parameter logic [4:0] HALT_OP = 5'b11011,
    parameter logic [4:0] NOP_OP  = 5'b01101
) (
    input  wire logic          clock,
    input  wire logic          clear,
    control_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_HALT  = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic             md_q, md_d;        // instruction class captured in T3
    logic [CNT_W-1:0] count_q, count_d;

    // Instruction field decode
    logic [4:0] w_op;
    logic [3:0] w_ra, w_rb, w_rc;
    logic       w_is_alu, w_is_md;
    logic       w_is_nop, w_is_halt, w_is_rsvd;
    logic       w_unused_ir;

    assign w_op        = bus.ir[31:27];
    assign w_ra        = bus.ir[26:23];
    assign w_rb        = bus.ir[22:19];
    assign w_rc        = bus.ir[18:15];
    assign w_unused_ir = ^bus.ir[14:0];

    assign w_is_alu  = (w_op <= 5'd12);
    assign w_is_md   = (w_op == 5'b01110) || (w_op == 5'b01111);
    assign w_is_nop  = (w_op == NOP_OP);
    assign w_is_halt = (w_op == HALT_OP);
    assign w_is_rsvd = !(w_is_alu || w_is_md || w_is_nop || w_is_halt);

    // Next-state, class latch and retire counter
    always_comb begin
        state_d = state_q;
        md_d    = md_q;
        count_d = count_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    if (bus.mem_ready) state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3: begin
                md_d = w_is_md;
                if (w_is_alu || w_is_md) begin
                    state_d = S_T4;
                end else if (w_is_halt) begin
                    state_d = S_HALT;
                end else begin
                    // nop and reserved opcodes retire straight from T3
                    state_d = S_T0;
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_T4:    state_d = S_T5;
            S_T5: begin
                if (md_q) begin
                    state_d = S_T6;
                end else begin
                    state_d = S_T0;
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_T6: begin
                state_d = S_T0;
                count_d = count_q + CNT_W'(1);
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_RESET;
            md_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            md_q    <= md_d;
            count_q <= count_d;
        end
    end

    assign bus.instr_count = count_q;

    // Strobes decode from the current state only (plus ir fields and the
    // T1 handshake), so they go quiet the instant clear forces RESET.
    always_comb begin
        bus.PCout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.Read     = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.reg_in   = 16'h0000;
        bus.reg_out  = 16'h0000;
        bus.opcode   = NOP_OP;
        bus.illegal  = 1'b0;
        bus.run      = (state_q != S_RESET) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                // PC loads only in the cycle the fetch completes
                bus.PCin    = bus.mem_ready;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (w_is_alu) begin
                    bus.reg_out = 16'h0001 << w_rb;
                    bus.Yin     = 1'b1;
                end else if (w_is_md) begin
                    bus.reg_out = 16'h0001 << w_ra;
                    bus.Yin     = 1'b1;
                end else if (w_is_rsvd) begin
                    bus.illegal = 1'b1;
                end
            end
            S_T4: begin
                bus.reg_out = 16'h0001 << (md_q ? w_rb : w_rc);
                bus.opcode  = w_op;
                bus.Zin     = 1'b1;
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (md_q) begin
                    bus.LOin = 1'b1;
                end else begin
                    bus.reg_in = 16'h0001 << w_ra;
                end
            end
            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire
